// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled start detection, mid-bit sampling of
// 5..8 data bits, optional even/odd parity, 1 or 2 stop bits, break handling.
module uart_receiver (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sample_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic [1:0] parity_mode_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rxs_q, rxs_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_acc_q, par_acc_d;
  logic        par_err_q, par_err_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  cfg_bits_q, cfg_bits_d;
  logic [1:0]  cfg_par_q, cfg_par_d;
  logic        cfg_stop2_q, cfg_stop2_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_out_q, ferr_out_d;
  logic        busy_q, busy_d;

  logic        par_en;
  logic        last_bit;
  logic        fe_now;

  assign par_en   = cfg_par_q[0] ^ cfg_par_q[1];
  // Index of the final data bit is N-1 = 4 + data_bits code.
  assign last_bit = (bcnt_q == {1'b1, cfg_bits_q});
  assign fe_now   = frame_err_q | ~rxs_q;

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx_i;
    rxs_d       = rx_meta_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    par_acc_d   = par_acc_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    cfg_bits_d  = cfg_bits_q;
    cfg_par_d   = cfg_par_q;
    cfg_stop2_d = cfg_stop2_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    perr_out_d  = 1'b0;
    ferr_out_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sample_i && !rxs_q) begin
          state_d = S_START;
          tcnt_d  = 4'd0;
        end
      end

      S_START: begin
        if (sample_i) begin
          if (tcnt_q != 4'd7) begin
            tcnt_d = tcnt_q + 4'd1;
          end else if (!rxs_q) begin
            state_d     = S_DATA;
            tcnt_d      = 4'd0;
            bcnt_d      = 3'd0;
            stop_cnt_d  = 1'b0;
            shreg_d     = 8'h00;
            par_acc_d   = 1'b0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
            cfg_bits_d  = data_bits_i;
            cfg_par_d   = parity_mode_i;
            cfg_stop2_d = stop_bits_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (sample_i) begin
          if (tcnt_q == 4'd15) begin
            shreg_d[bcnt_q] = rxs_q;
            par_acc_d       = par_acc_q ^ rxs_q;
            tcnt_d          = 4'd0;
            bcnt_d          = bcnt_q + 3'd1;
            if (last_bit) begin
              state_d = par_en ? S_PARITY : S_STOP;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (sample_i) begin
          if (tcnt_q == 4'd15) begin
            // Odd mode (code 10) expects an overall XOR of 1, so invert.
            par_err_d = par_acc_q ^ rxs_q ^ cfg_par_q[1];
            tcnt_d    = 4'd0;
            state_d   = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (sample_i) begin
          if (tcnt_q == 4'd15) begin
            tcnt_d      = 4'd0;
            frame_err_d = fe_now;
            if (cfg_stop2_q && !stop_cnt_q) begin
              stop_cnt_d = 1'b1;
            end else begin
              stop_cnt_d = 1'b0;
              valid_d    = 1'b1;
              data_out_d = shreg_q;
              perr_out_d = par_err_q;
              ferr_out_d = fe_now;
              // A line still low after a framing error is a break: park until it rises.
              state_d    = (fe_now && !rxs_q) ? S_WAIT_HIGH : S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value computed by the always_comb block above.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tcnt_q      <= 4'd0;
      bcnt_q      <= 3'd0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= 8'h00;
      par_acc_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_bits_q  <= 2'b00;
      cfg_par_q   <= 2'b00;
      cfg_stop2_q <= 1'b0;
      data_out_q  <= 8'h00;
      valid_q     <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shreg_q     <= shreg_d;
      par_acc_q   <= par_acc_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      cfg_bits_q  <= cfg_bits_d;
      cfg_par_q   <= cfg_par_d;
      cfg_stop2_q <= cfg_stop2_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o         = data_out_q;
  assign valid_o        = valid_q;
  assign parity_error_o = perr_out_q;
  assign frame_error_o  = ferr_out_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expectations,
// a negedge monitor pops and compares on every valid_o pulse.
module tb_uart_receiver;

  localparam int CLKS_PER_TICK = 3;
  localparam int BIT_CLKS      = 16 * CLKS_PER_TICK;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       sample_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [1:0] data_bits_i = 2'b11;
  logic [1:0] parity_mode_i = 2'b00;
  logic       stop_bits_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_error_o;
  logic       frame_error_o;
  logic       busy_o;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        fe;
    int unsigned drop_pos;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned pos_cnt = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  uart_receiver dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sample_i       (sample_i),
    .rx_i           (rx_i),
    .data_bits_i    (data_bits_i),
    .parity_mode_i  (parity_mode_i),
    .stop_bits_i    (stop_bits_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .parity_error_o (parity_error_o),
    .frame_error_o  (frame_error_o),
    .busy_o         (busy_o)
  );

  // Clock plus a tick on every third rising edge.
  initial begin
    forever begin
      #5 clk_i = 1'b1;
      pos_cnt++;
      #5 clk_i = 1'b0;
      cyc++;
      sample_i = (cyc % CLKS_PER_TICK == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bit_time(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  // Drops the line just before a tick edge so the detection tick lands
  // exactly 3 rising edges later; drop is the edge count at that moment.
  task automatic start_frame(output int unsigned drop);
    do begin
      @(negedge clk_i);
      #1;
    end while (!sample_i);
    rx_i = 1'b0;
    drop = pos_cnt;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input int has_par,
                            input logic par_bit, input int nstop, input logic stop2,
                            input logic [7:0] exp_data, input logic exp_pe, input logic exp_fe);
    int unsigned drop;
    exp_t e;
    start_frame(drop);
    e.data = exp_data;
    e.pe = exp_pe;
    e.fe = exp_fe;
    e.drop_pos = drop;
    e.lat = CLKS_PER_TICK * (8 + 16 * (n + has_par + nstop)) + 4;
    sb.push_back(e);
    repeat (BIT_CLKS) @(negedge clk_i);
    for (int i = 0; i < n; i++) bit_time(d[i]);
    if (has_par != 0) bit_time(par_bit);
    bit_time(1'b1);
    if (nstop == 2) bit_time(stop2);
    rx_i = 1'b1;
  endtask

  // Monitor: compare each delivered character against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      if (valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: data 0x%0h with empty scoreboard at %0t", data_o, $time);
        end else begin
          mon_e = sb.pop_front();
          check("data", {24'd0, data_o}, {24'd0, mon_e.data});
          check("parity_err", {31'd0, parity_error_o}, {31'd0, mon_e.pe});
          check("frame_err", {31'd0, frame_error_o}, {31'd0, mon_e.fe});
          check("latency", pos_cnt - mon_e.drop_pos, mon_e.lat);
        end
      end else if (rst_n_i) begin
        check("flags_idle", {30'd0, parity_error_o, frame_error_o}, 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, {24'd0, data_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_pe"}, {31'd0, parity_error_o}, 32'd0);
    check({tag, "_fe"}, {31'd0, frame_error_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int unsigned drop;
    int waited;
    exp_t e;

    repeat (4) @(negedge clk_i);
    #1;
    check_all_zero("reset");
    rst_n_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk_i);

    // 8N1 nominal
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0);

    // 7E1: 0x41 has two ones, so the correct even parity bit is 0
    data_bits_i = 2'b10;
    parity_mode_i = 2'b01;
    send_frame(8'h41, 7, 1, 1'b1, 1, 1'b1, 8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 7, 1, 1'b0, 1, 1'b1, 8'h41, 1'b0, 1'b0);

    // 8O1: 0xA5 has four ones (odd bit 1); 0x07 has three (odd bit 0)
    data_bits_i = 2'b11;
    parity_mode_i = 2'b10;
    send_frame(8'hA5, 8, 1, 1'b1, 1, 1'b1, 8'hA5, 1'b0, 1'b0);
    send_frame(8'h07, 8, 1, 1'b1, 1, 1'b1, 8'h07, 1'b1, 1'b0);

    // 8N2 with a low second stop bit, then a clean frame
    parity_mode_i = 2'b00;
    stop_bits_i = 1'b1;
    send_frame(8'h3C, 8, 0, 1'b0, 2, 1'b0, 8'h3C, 1'b0, 1'b1);
    bit_time(1'b1);
    send_frame(8'h55, 8, 0, 1'b0, 2, 1'b1, 8'h55, 1'b0, 1'b0);
    stop_bits_i = 1'b0;
    bit_time(1'b1);

    // Reset in the middle of data bit 3 of 0xFF
    start_frame(drop);
    repeat (BIT_CLKS) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (3 * BIT_CLKS + 20) @(negedge clk_i);
    check("midframe_busy", {31'd0, busy_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk_i);
    send_frame(8'h12, 8, 0, 1'b0, 1, 1'b1, 8'h12, 1'b0, 1'b0);
    bit_time(1'b1);

    // Glitch: four ticks low must not produce a character
    start_frame(drop);
    repeat (4 * CLKS_PER_TICK) @(negedge clk_i);
    rx_i = 1'b1;
    check("glitch_busy_high", {31'd0, busy_o}, 32'd1);
    repeat (BIT_CLKS) @(negedge clk_i);
    check("glitch_busy_low", {31'd0, busy_o}, 32'd0);

    // Break: 30 bit times low gives one all-zero frame with a framing error
    start_frame(drop);
    e.data = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.drop_pos = drop;
    e.lat = CLKS_PER_TICK * (8 + 16 * 9) + 4;
    sb.push_back(e);
    repeat (30 * BIT_CLKS) @(negedge clk_i);
    check("break_busy_held", {31'd0, busy_o}, 32'd1);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    check("break_busy_released", {31'd0, busy_o}, 32'd0);

    // 5N1 with the width input changed mid-frame
    data_bits_i = 2'b00;
    fork
      send_frame(8'h15, 5, 0, 1'b0, 1, 1'b1, 8'h15, 1'b0, 1'b0);
      begin
        repeat (2 * BIT_CLKS) @(negedge clk_i);
        data_bits_i = 2'b11;
      end
    join
    bit_time(1'b1);

    waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    check("scoreboard_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver. It consumes the one-cycle 16x-oversampling pulse from the UART baud generator and recovers frames from an asynchronous `rx_i` line. Frames have 5 to 8 data bits sent LSB first, optional even or odd parity, and 1 or 2 stop bits. Each received character is delivered as a one-cycle `valid_o` pulse with error flags, towards the UART RX FIFO and status registers.

## Interface
Parameters:
- none. Frame format is runtime-configurable through ports.

Ports:
- `clk_i`  in  1  system clock. Single clock domain.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `sample_i`  in  1  oversampling tick, one `clk_i` cycle wide, 16 per bit time. Driven by the baud generator.
- `rx_i`  in  1  serial line. Idle high, asynchronous to `clk_i`.
- `data_bits_i`  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
- `parity_mode_i`  in  2  parity: 00=none, 01=even, 10=odd, 11=none.
- `stop_bits_i`  in  1  stop bits: 0=1, 1=2.
- `data_o`  out  8  received character, right-aligned. Unused upper bits are 0.
- `valid_o`  out  1  one-cycle pulse: `data_o` and the error flags are valid.
- `parity_error_o`  out  1  parity mismatch. Qualified by `valid_o`.
- `frame_error_o`  out  1  a stop bit was sampled low. Qualified by `valid_o`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- **Input synchronizer.** `rx_i` passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value `rxs`.
- **Counters.**
  - 4-bit tick counter `tcnt`.
  - 3-bit data bit index `bcnt`.
  - Stop bit counter.
- **Counter rule.** Counters only change on cycles where `sample_i`=1. Between ticks, nothing changes except the output pulse logic.
- **Config latching.** `data_bits_i`, `parity_mode_i` and `stop_bits_i` are latched when the start bit is confirmed. Changes mid-frame have no effect on the current frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - **IDLE:** on a tick with `rxs`=0, go to START and set `tcnt`<=0.
  - **START:**
    - On a tick with `tcnt`!=7, increment `tcnt`.
    - On a tick with `tcnt`==7 (mid-bit): if `rxs`=0, go to DATA with `tcnt`<=0, `bcnt`<=0, and the data register cleared. If `rxs`=1, the start was a glitch: return to IDLE and produce no output.
  - **DATA:**
    - On a tick with `tcnt`==15, write `data[bcnt]`<=`rxs`, set `tcnt`<=0 and increment `bcnt`.
    - After bit N-1, go to PARITY if parity is enabled, else go to STOP.
    - Otherwise increment `tcnt`.
  - **PARITY:**
    - On a tick with `tcnt`==15, sample the parity bit and go to STOP.
    - Even mode: error if XOR(data bits, parity bit)=1.
    - Odd mode: error if XOR(data bits, parity bit)=0.
  - **STOP:**
    - On a tick with `tcnt`==15, sample the stop bit. A low stop bit sets the sticky `frame_err`.
    - With 2 stop bits, sample the second stop bit 16 ticks later, applying the same rule.
    - After the final stop sample, deliver the frame:
      - If `frame_err`=1 and `rxs`=0, go to WAIT_HIGH.
      - Otherwise go to IDLE.
  - **WAIT_HIGH (break handling):** stay until `rxs`=1 on any cycle, then go to IDLE. This prevents a held-low line from generating repeated frames.
- **Delivery.**
  - `data_o`, `parity_error_o` and `frame_error_o` are registered in the cycle after the final stop sample tick.
  - `valid_o`=1 for exactly that one cycle.
  - `data_o` holds its value until the next delivery.
  - The error flags are cleared whenever `valid_o`=0.
- **Error frames are still delivered.** A frame with a frame or parity error is delivered with its data.
- **Reset mid-frame:** the FSM returns to IDLE immediately. The partial frame is discarded and no `valid_o` is produced.

## Timing
- **Reset values:**
  - `data_o`=0x00.
  - `valid_o`, `parity_error_o`, `frame_error_o`, `busy_o` = 0.
  - Synchronizer = 1.
  - FSM in IDLE, all counters 0.
- **Synchronizer latency:** 2 `clk_i` cycles from an `rx_i` edge to `rxs`.
- **Sample points:** the start bit is checked 8 ticks after detection. Every later bit is sampled 16 ticks after the previous sample, i.e. at mid-bit.
- **Frame latency:** with N data bits, P parity bits (0/1) and S stop bits (1/2), `valid_o` rises 1 cycle after tick number 8+16·(N+P+S) counted from the detection tick.
- **Back-to-back frames:** a new start bit can be detected on the first tick after returning to IDLE. No extra idle time is required beyond the stop bit(s).
- **`sample_i` held high:** every cycle counts as a tick. This is legal, for simulation speed-up.

## Test plan
- **8N1 nominal:** send 0xA5 → `valid_o` pulses once, `data_o`=0xA5, both error flags 0, latency = 8+16·9 ticks + 1 cycle.
- **7E1 parity error:** send 0x41 with parity bit 1 (correct bit is 0) → `data_o`=0x41, `parity_error_o`=1. Resend with parity bit 0 → `parity_error_o`=0.
- **8N2 frame error:** send 0x3C with the second stop bit low → `data_o`=0x3C, `frame_error_o`=1. Then return the line high and send 0x55 → `data_o`=0x55, no errors.
- **Glitch and break:**
  - Glitch: drive `rx_i` low for 4 ticks → no `valid_o`, back to IDLE, `busy_o` deasserts.
  - Break: hold `rx_i` low for 30 bit times → exactly one `valid_o` with `data_o`=0x00 and `frame_error_o`=1, no further pulses until the line goes high.
- **Reset mid-frame:** assert `rst_n_i` low during bit 3 of 0xFF → all outputs 0 immediately. Release, then send 0x12 → `data_o`=0x12, no errors.
- **5N1 alignment:** send 0x15 → `data_o`=0x15, upper 3 bits 0. Change `data_bits_i` mid-frame → current frame still decoded as 5-bit.
